// File: rtl/pairhmm_job_sched_pkg.sv
// PairHMM job scheduler: shared parameters and result word layout.
// Imported by the interface, the round-robin picker and the top.
package pairhmm_sched_pkg;

    localparam int NUM_ENG   = 6;
    localparam int ID_W      = 8;
    localparam int LEN_W     = 10;
    localparam int SUM_W     = 64;
    localparam int ENG_IDX_W = $clog2(NUM_ENG);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [SUM_W-1:0] sum;
    } res_t;

    function automatic logic [ENG_IDX_W-1:0] idx_inc(
        input logic [ENG_IDX_W-1:0] i
    );
        return (int'(i) == NUM_ENG - 1) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/pairhmm_job_sched_if.sv
// Descriptor, engine and result-FIFO signals of the PairHMM job scheduler.
// master = parser/engines/FIFO side, slave = the scheduler.
interface pairhmm_job_sched_if;
    import pairhmm_sched_pkg::*;

    logic                     job_vld;
    logic                     job_rdy;
    logic [ID_W-1:0]          job_id;
    logic [LEN_W-1:0]         job_rlen;
    logic [LEN_W-1:0]         job_hlen;
    logic [NUM_ENG-1:0]       eng_start;
    logic [LEN_W-1:0]         eng_rlen;
    logic [LEN_W-1:0]         eng_hlen;
    logic [NUM_ENG-1:0]       eng_sum_vld;
    logic [NUM_ENG*SUM_W-1:0] eng_sum;
    logic                     res_wr;
    res_t                     res_wdat;
    logic                     res_full;
    logic [31:0]              done_cnt;
    logic [15:0]              err_cnt;

    modport master (
        output job_vld, job_id, job_rlen, job_hlen,
        output eng_sum_vld, eng_sum, res_full,
        input  job_rdy, eng_start, eng_rlen, eng_hlen,
        input  res_wr, res_wdat, done_cnt, err_cnt
    );

    modport slave (
        input  job_vld, job_id, job_rlen, job_hlen,
        input  eng_sum_vld, eng_sum, res_full,
        output job_rdy, eng_start, eng_rlen, eng_hlen,
        output res_wr, res_wdat, done_cnt, err_cnt
    );

endinterface

// File: rtl/pairhmm_job_sched_rr_pick.sv
// Cyclic first-set search: lowest set bit of req at or after ptr.
// Purely combinational; used for both dispatch and collection.
module rr_pick
    import pairhmm_sched_pkg::*;
(
    input  logic [NUM_ENG-1:0]   req,
    input  logic [ENG_IDX_W-1:0] ptr,
    output logic                 gnt_vld,
    output logic [ENG_IDX_W-1:0] gnt_idx
);

    localparam logic [ENG_IDX_W:0] N_L = (ENG_IDX_W + 1)'(NUM_ENG);

    logic [2*NUM_ENG-1:0] dbl;
    logic [NUM_ENG-1:0]   rot;
    logic [ENG_IDX_W:0]   raw;

    // Rotate so that bit 0 of rot is the engine at ptr.
    assign dbl = {req, req};
    assign rot = NUM_ENG'(dbl >> ptr);

    always_comb begin
        gnt_vld = 1'b0;
        raw     = '0;
        for (int i = NUM_ENG - 1; i >= 0; i--) begin
            if (rot[i]) begin
                gnt_vld = 1'b1;
                raw     = {1'b0, ptr} + (ENG_IDX_W + 1)'(i);
            end
        end
    end

    assign gnt_idx = (raw >= N_L) ? ENG_IDX_W'(raw - N_L)
                                  : raw[ENG_IDX_W-1:0];

endmodule

// File: rtl/pairhmm_job_sched.sv
// PairHMM job scheduler: round-robin dispatch of descriptors to engines,
// tag tracking, and round-robin serialisation of results to the FIFO.
module pairhmm_job_sched
    import pairhmm_sched_pkg::*;
(
    input logic                sys_clk,
    input logic                sys_rst_n,
    pairhmm_job_sched_if.slave bus
);

    logic [NUM_ENG-1:0]   busy;
    logic [NUM_ENG-1:0]   pend;
    logic [SUM_W-1:0]     pend_sum [NUM_ENG];
    logic [ID_W-1:0]      tag      [NUM_ENG];
    logic [ENG_IDX_W-1:0] disp_ptr;
    logic [ENG_IDX_W-1:0] col_ptr;
    logic                 live;

    logic [ENG_IDX_W-1:0] disp_idx;
    logic [ENG_IDX_W-1:0] col_idx;
    logic                 disp_vld;
    logic                 col_vld;
    logic                 accept;
    logic                 zero_len;
    logic                 do_disp;
    logic                 do_col;
    logic [NUM_ENG-1:0]   disp_oh;
    logic [NUM_ENG-1:0]   col_oh;
    logic [NUM_ENG-1:0]   cap;
    logic [NUM_ENG-1:0]   spur;
    logic [3:0]           err_inc;
    logic [16:0]          err_sum;

    rr_pick u_disp (
        .req     (~busy),
        .ptr     (disp_ptr),
        .gnt_vld (disp_vld),
        .gnt_idx (disp_idx)
    );

    rr_pick u_col (
        .req     (pend),
        .ptr     (col_ptr),
        .gnt_vld (col_vld),
        .gnt_idx (col_idx)
    );

    // live keeps job_rdy low while reset is held.
    assign bus.job_rdy = live & ~&busy;
    assign accept      = bus.job_vld & bus.job_rdy;
    assign zero_len    = (bus.job_rlen == '0) | (bus.job_hlen == '0);
    assign do_disp     = accept & ~zero_len & disp_vld;
    assign do_col      = col_vld & ~bus.res_full;

    assign disp_oh = do_disp ? NUM_ENG'(1) << disp_idx : '0;
    assign col_oh  = do_col  ? NUM_ENG'(1) << col_idx  : '0;

    // A strobe is only valid for a busy engine with no result waiting.
    assign cap  = bus.eng_sum_vld & busy & ~pend;
    assign spur = bus.eng_sum_vld & ~cap;

    always_comb begin
        err_inc = 4'(accept & zero_len);
        for (int k = 0; k < NUM_ENG; k++)
            err_inc = err_inc + 4'(spur[k]);
        err_sum = {1'b0, bus.err_cnt} + 17'(err_inc);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            live          <= 1'b0;
            busy          <= '0;
            pend          <= '0;
            disp_ptr      <= '0;
            col_ptr       <= '0;
            bus.eng_start <= '0;
            bus.eng_rlen  <= '0;
            bus.eng_hlen  <= '0;
            bus.res_wr    <= 1'b0;
            bus.res_wdat  <= '0;
            bus.done_cnt  <= '0;
            bus.err_cnt   <= '0;
            for (int k = 0; k < NUM_ENG; k++) begin
                pend_sum[k] <= '0;
                tag[k]      <= '0;
            end
        end else begin
            live          <= 1'b1;
            busy          <= (busy | disp_oh) & ~col_oh;
            pend          <= (pend | cap) & ~col_oh;
            bus.eng_start <= disp_oh;
            bus.eng_rlen  <= do_disp ? bus.job_rlen : '0;
            bus.eng_hlen  <= do_disp ? bus.job_hlen : '0;
            bus.res_wr    <= do_col;
            bus.err_cnt   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (do_disp) begin
                tag[disp_idx] <= bus.job_id;
                disp_ptr      <= idx_inc(disp_idx);
            end
            for (int k = 0; k < NUM_ENG; k++) begin
                if (cap[k])
                    pend_sum[k] <= bus.eng_sum[k*SUM_W +: SUM_W];
            end
            if (do_col) begin
                bus.res_wdat <= '{id: tag[col_idx], sum: pend_sum[col_idx]};
                col_ptr      <= idx_inc(col_idx);
                bus.done_cnt <= bus.done_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pairhmm_job_sched.sv
// Bench for pairhmm_job_sched: directed tables and sequences plus random
// traffic, all cross-checked every cycle against a transaction-level model.
module tb_pairhmm_job_sched;
    import pairhmm_sched_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    pairhmm_job_sched_if bus();

    pairhmm_job_sched dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit                   m_live;
    bit [NUM_ENG-1:0]     m_busy;
    bit [NUM_ENG-1:0]     m_pend;
    logic [SUM_W-1:0]     m_psum [NUM_ENG];
    logic [ID_W-1:0]      m_tag  [NUM_ENG];
    int                   m_dptr;
    int                   m_cptr;
    logic [31:0]          m_done;
    int                   m_err;
    logic [NUM_ENG-1:0]   e_start;
    logic [LEN_W-1:0]     e_rlen;
    logic [LEN_W-1:0]     e_hlen;
    bit                   e_wr;
    logic [ID_W+SUM_W-1:0] e_wdat;

    typedef struct {
        logic [ID_W-1:0]    id;
        logic [LEN_W-1:0]   rlen;
        logic [LEN_W-1:0]   hlen;
        logic [NUM_ENG-1:0] start;
    } fill_t;

    typedef struct {
        int                    eng;
        logic [ID_W+SUM_W-1:0] wdat;
    } ooo_t;

    fill_t      fill_tbl [6];
    ooo_t       ooo_tbl  [3];
    logic [7:0] sim_tag  [6];
    int         cnt      [NUM_ENG];

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int first_from(bit [NUM_ENG-1:0] v, int p);
        for (int o = 0; o < NUM_ENG; o++)
            if (v[(p + o) % NUM_ENG]) return (p + o) % NUM_ENG;
        return -1;
    endfunction

    task automatic model_reset();
        m_live = 0; m_busy = '0; m_pend = '0;
        m_dptr = 0; m_cptr = 0; m_done = '0; m_err = 0;
        e_start = '0; e_rlen = '0; e_hlen = '0;
        e_wr = 0; e_wdat = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            m_psum[k] = '0;
            m_tag[k]  = '0;
        end
    endtask

    // One clock of the scheduler's rules, using pre-edge state and inputs.
    task automatic model_step();
        bit [NUM_ENG-1:0] ob;
        bit [NUM_ENG-1:0] op;
        bit rdy;
        int errs;
        int k;
        ob = m_busy;
        op = m_pend;
        rdy = m_live && (ob != '1);
        errs = 0;
        e_start = '0;
        e_wr = 0;
        if (bus.job_vld && rdy) begin
            if (bus.job_rlen == 0 || bus.job_hlen == 0) begin
                errs++;
            end else begin
                k = first_from(~ob, m_dptr);
                m_busy[k] = 1;
                m_tag[k] = bus.job_id;
                m_dptr = (k + 1) % NUM_ENG;
                e_start[k] = 1'b1;
                e_rlen = bus.job_rlen;
                e_hlen = bus.job_hlen;
            end
        end
        if (op != 0 && !bus.res_full) begin
            k = first_from(op, m_cptr);
            e_wr = 1;
            e_wdat = {m_tag[k], m_psum[k]};
            m_pend[k] = 0;
            m_busy[k] = 0;
            m_cptr = (k + 1) % NUM_ENG;
            m_done = m_done + 1;
        end
        for (int j = 0; j < NUM_ENG; j++) begin
            if (bus.eng_sum_vld[j]) begin
                if (ob[j] && !op[j]) begin
                    m_pend[j] = 1;
                    m_psum[j] = bus.eng_sum[j*SUM_W +: SUM_W];
                end else begin
                    errs++;
                end
            end
        end
        m_err = (m_err + errs > 65535) ? 65535 : m_err + errs;
        m_live = 1;
    endtask

    task automatic compare_all();
        chk("rdy", bus.job_rdy, m_live && (m_busy != '1));
        chk("start", bus.eng_start, e_start);
        if (e_start != 0) begin
            chk("rlen", bus.eng_rlen, e_rlen);
            chk("hlen", bus.eng_hlen, e_hlen);
        end
        chk("wr", bus.res_wr, e_wr);
        if (e_wr) chk("wdat", bus.res_wdat, e_wdat);
        chk("done", bus.done_cnt, m_done);
        chk("err", bus.err_cnt, 16'(m_err));
    endtask

    task automatic cyc();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic job(logic [ID_W-1:0] id, logic [LEN_W-1:0] rl, logic [LEN_W-1:0] hl);
        bus.job_vld  = 1'b1;
        bus.job_id   = id;
        bus.job_rlen = rl;
        bus.job_hlen = hl;
    endtask

    initial begin
        fill_tbl[0] = '{8'h10, 10'd4, 10'd4, 6'h01};
        fill_tbl[1] = '{8'h11, 10'd4, 10'd4, 6'h02};
        fill_tbl[2] = '{8'h12, 10'd4, 10'd4, 6'h04};
        fill_tbl[3] = '{8'h13, 10'd4, 10'd4, 6'h08};
        fill_tbl[4] = '{8'h14, 10'd4, 10'd4, 6'h10};
        fill_tbl[5] = '{8'h15, 10'd4, 10'd4, 6'h20};
        ooo_tbl[0]  = '{3, {8'h13, 64'h103}};
        ooo_tbl[1]  = '{0, {8'h10, 64'h100}};
        ooo_tbl[2]  = '{5, {8'h15, 64'h105}};
        sim_tag     = '{8'h20, 8'h11, 8'h12, 8'h21, 8'h14, 8'h22};

        bus.job_vld = 0; bus.job_id = '0;
        bus.job_rlen = '0; bus.job_hlen = '0;
        bus.eng_sum_vld = '0; bus.res_full = 0;
        for (int k = 0; k < NUM_ENG; k++)
            bus.eng_sum[k*SUM_W +: SUM_W] = 64'(k + 'h100);
        model_reset();

        // Reset state
        #1 rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_rdy", bus.job_rdy, 1'b0);
        chk("rst_start", bus.eng_start, 6'h0);
        chk("rst_rlen", bus.eng_rlen, 10'h0);
        chk("rst_wr", bus.res_wr, 1'b0);
        chk("rst_wdat", bus.res_wdat, 72'h0);
        chk("rst_done", bus.done_cnt, 32'h0);
        chk("rst_err", bus.err_cnt, 16'h0);
        rst_n = 1'b1;
        cyc();
        chk("rdy_after_rst", bus.job_rdy, 1'b1);

        // Fill all engines back-to-back
        for (int i = 0; i < 6; i++) begin
            job(fill_tbl[i].id, fill_tbl[i].rlen, fill_tbl[i].hlen);
            cyc();
            chk("fill_start", bus.eng_start, fill_tbl[i].start);
        end
        chk("fill_rdy", bus.job_rdy, 1'b0);
        job(8'h16, 10'd4, 10'd4);
        repeat (3) begin
            cyc();
            chk("stall_start", bus.eng_start, 6'h0);
        end
        bus.job_vld = 0;

        // Out-of-order completion 3,0,5
        for (int i = 0; i < 4; i++) begin
            if (i < 3) bus.eng_sum_vld = 6'(1 << ooo_tbl[i].eng);
            else bus.eng_sum_vld = '0;
            cyc();
            if (i > 0) begin
                chk("ooo_wr", bus.res_wr, 1'b1);
                chk("ooo_wdat", bus.res_wdat, ooo_tbl[i-1].wdat);
            end
        end
        cyc();
        chk("ooo_done", bus.done_cnt, 32'd3);
        chk("ooo_idle", bus.res_wr, 1'b0);

        // Refill engines 0,3,5
        for (int i = 0; i < 3; i++) begin
            job(8'(32 + i), 10'd4, 10'd4);
            cyc();
        end
        bus.job_vld = 0;

        // All strobes at once, stalled job waiting
        job(8'h16, 10'd4, 10'd4);
        bus.eng_sum_vld = '1;
        cyc();
        bus.eng_sum_vld = '0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("sim_wr", bus.res_wr, 1'b1);
            chk("sim_wdat", bus.res_wdat, {sim_tag[i], 64'(i + 256)});
            if (i == 1) begin
                chk("sim_start7", bus.eng_start, 6'h01);
                bus.job_vld = 0;
            end
        end

        // Backpressure with two results pending
        job(8'h30, 10'd7, 10'd9);
        cyc();
        chk("bp_disp", bus.eng_start, 6'h02);
        bus.job_vld = 0;
        bus.res_full = 1;
        bus.eng_sum_vld = 6'h03;
        cyc();
        bus.eng_sum_vld = '0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_hold", bus.res_wr, 1'b0);
        end
        bus.res_full = 0;
        cyc();
        chk("bp_wdat0", bus.res_wdat, {8'h16, 64'h100});
        cyc();
        chk("bp_wr1", bus.res_wr, 1'b1);
        chk("bp_wdat1", bus.res_wdat, {8'h30, 64'h101});

        // Protocol errors
        job(8'h40, 10'd0, 10'd4);
        cyc();
        bus.job_vld = 0;
        chk("err_nostart", bus.eng_start, 6'h0);
        chk("err_zero", bus.err_cnt, 16'd1);
        bus.eng_sum_vld = 6'h04;
        cyc();
        bus.eng_sum_vld = '0;
        chk("err_spur", bus.err_cnt, 16'd2);
        cyc();
        chk("err_nowr", bus.res_wr, 1'b0);

        // Reset with 4 busy, 2 pending
        for (int i = 0; i < 4; i++) begin
            job(8'(80 + i), 10'd5, 10'd5);
            cyc();
        end
        bus.job_vld = 0;
        bus.res_full = 1;
        bus.eng_sum_vld = 6'h0C;
        cyc();
        bus.eng_sum_vld = '0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_rdy", bus.job_rdy, 1'b0);
        chk("arst_wr", bus.res_wr, 1'b0);
        chk("arst_done", bus.done_cnt, 32'h0);
        chk("arst_err", bus.err_cnt, 16'h0);
        bus.res_full = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("arst_rdy1", bus.job_rdy, 1'b1);
        repeat (3) begin
            cyc();
            chk("arst_nowr", bus.res_wr, 1'b0);
        end

        // Random traffic against the model
        for (int k = 0; k < NUM_ENG; k++) cnt[k] = -1;
        repeat (3000) begin
            logic [NUM_ENG-1:0] sv;
            int r;
            sv = '0;
            for (int k = 0; k < NUM_ENG; k++) begin
                if (cnt[k] == 0) begin
                    sv[k] = 1'b1;
                    cnt[k] = -1;
                end else if (cnt[k] > 0) begin
                    cnt[k]--;
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                r = int'($urandom_range(0, NUM_ENG - 1));
                sv[r] = 1'b1;
            end
            bus.eng_sum_vld = sv;
            for (int k = 0; k < NUM_ENG; k++)
                bus.eng_sum[k*SUM_W +: SUM_W] = {$urandom, $urandom};
            bus.job_vld  = 1'($urandom_range(0, 1));
            bus.job_id   = 8'($urandom);
            bus.job_rlen = ($urandom_range(0, 15) == 0) ? '0 : 10'($urandom_range(1, 1023));
            bus.job_hlen = ($urandom_range(0, 15) == 0) ? '0 : 10'($urandom_range(1, 1023));
            bus.res_full = ($urandom_range(0, 3) == 0);
            cyc();
            for (int k = 0; k < NUM_ENG; k++)
                if (bus.eng_start[k]) cnt[k] = int'($urandom_range(0, 12));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
